// File: rtl/syn_pipe_sequencer.sv
// Pipeline sequencer for the five-stage core: per-stage enables and clears,
// halt drain with timeout, and saturating debug counters.
module syn_pipe_sequencer #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_MAX = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             step_mode,
   input  logic             step_req,
   input  logic             bubble,
   input  logic             load_pc,
   input  logic             halt_ex,
   input  logic             halted_wb,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_clr_n,
   output logic             id_ex_en,
   output logic             id_ex_clr_n,
   output logic             ex_dm_en,
   output logic             dm_wb_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [DW-1:0]    r_drainCnt;
   logic [DW-1:0]    w_drainNext;
   logic [DW-1:0]    w_drainInc;
   logic [CNT_W-1:0] r_cycleCnt;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;
   logic             w_adv;
   logic             w_cycInc;
   logic             w_stallInc;
   logic             w_flushInc;

   assign w_adv      = en && (!step_mode || step_req);
   assign w_drainInc = r_drainCnt + DW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_drainCnt <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_drainCnt <= w_drainNext;
      end
   end

   // A taken branch keeps the front end moving even when a wrong-path
   // bubble is requested; a halt in the same cycle still flushes IF/ID.
   always_comb begin
      w_stateNext = r_state;
      w_drainNext = r_drainCnt;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_clr_n = 1'b1;
      id_ex_en    = 1'b0;
      id_ex_clr_n = 1'b1;
      ex_dm_en    = 1'b0;
      dm_wb_en    = 1'b0;
      w_cycInc    = 1'b0;
      w_stallInc  = 1'b0;
      w_flushInc  = 1'b0;
      case (r_state)
         ST_RUN: begin
            pc_en       = w_adv && (load_pc || !bubble);
            if_id_en    = w_adv && (load_pc || !bubble);
            if_id_clr_n = !(w_adv && load_pc);
            id_ex_en    = w_adv;
            id_ex_clr_n = !(w_adv && (load_pc || bubble));
            ex_dm_en    = w_adv;
            dm_wb_en    = w_adv;
            w_cycInc    = w_adv;
            w_stallInc  = w_adv && bubble && !load_pc;
            w_flushInc  = w_adv && load_pc;
            if (w_adv && halt_ex) begin
               w_stateNext = ST_DRAIN;
               w_drainNext = '0;
            end
         end
         ST_DRAIN: begin
            id_ex_en    = w_adv;
            id_ex_clr_n = !w_adv;
            ex_dm_en    = w_adv;
            dm_wb_en    = w_adv;
            w_cycInc    = w_adv;
            if (w_adv) begin
               w_drainNext = w_drainInc;
            end
            if (halted_wb) begin
               w_stateNext = ST_HALT;
            end else if (w_adv && (w_drainInc >= DW'(DRAIN_MAX))) begin
               w_stateNext = ST_ERR;
            end
         end
         default: begin
            w_stateNext = r_state;
         end
      endcase
   end

   // Debug counters saturate at all-ones so long runs never wrap to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycleCnt <= '0;
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (w_cycInc && (r_cycleCnt != '1)) begin
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
         end
         if (w_stallInc && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_flushInc && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign state     = r_state;
   assign halted    = (r_state == ST_HALT) || (r_state == ST_ERR);
   assign cycle_cnt = r_cycleCnt;
   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_syn_pipe_sequencer.sv
// Self-checking bench for syn_pipe_sequencer: directed vector table, halt and
// saturation sequences, and randomized traffic against a behavioural model.
module tb_syn_pipe_sequencer;

   localparam int CNT_W     = 8;
   localparam int DRAIN_MAX = 3;
   localparam int SAT       = 255;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             step_mode;
   logic             step_req;
   logic             bubble;
   logic             load_pc;
   logic             halt_ex;
   logic             halted_wb;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_clr_n;
   logic             id_ex_en;
   logic             id_ex_clr_n;
   logic             ex_dm_en;
   logic             dm_wb_en;
   logic [1:0]       state;
   logic             halted;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int testsRun    = 0;
   int testsFailed = 0;

   int mState;
   int mDrain;
   int mCyc;
   int mStall;
   int mFlush;

   typedef struct {
      logic       en;
      logic       sm;
      logic       sr;
      logic       b;
      logic       lp;
      logic [6:0] expEn;
      int         cycInc;
      int         stallInc;
      int         flushInc;
   } vec_t;

   vec_t vecs[10];

   syn_pipe_sequencer #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .step_mode(step_mode),
      .step_req(step_req), .bubble(bubble), .load_pc(load_pc),
      .halt_ex(halt_ex), .halted_wb(halted_wb), .pc_en(pc_en),
      .if_id_en(if_id_en), .if_id_clr_n(if_id_clr_n), .id_ex_en(id_ex_en),
      .id_ex_clr_n(id_ex_clr_n), .ex_dm_en(ex_dm_en), .dm_wb_en(dm_wb_en),
      .state(state), .halted(halted), .cycle_cnt(cycle_cnt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enable bundle order: {pc, if_id, if_id_clr_n, id_ex, id_ex_clr_n, ex_dm, dm_wb}
   function automatic logic [6:0] packEn();
      return {pc_en, if_id_en, if_id_clr_n, id_ex_en, id_ex_clr_n, ex_dm_en, dm_wb_en};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic sm, input logic sr, input logic b,
                                input logic lp, input logic he, input logic hw);
      en        = e;
      step_mode = sm;
      step_req  = sr;
      bubble    = b;
      load_pc   = lp;
      halt_ex   = he;
      halted_wb = hw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic checkCounters(input string tag, input int c, input int s, input int f);
      checkOutput({tag, " cycle_cnt"}, 32'(cycle_cnt), c);
      checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), s);
      checkOutput({tag, " flush_cnt"}, 32'(flush_cnt), f);
   endtask

   function automatic int satInc(input int v);
      return (v < SAT) ? v + 1 : v;
   endfunction

   // Expected enables from the sequencing rules, given the model's mode.
   function automatic logic [6:0] modelEn();
      logic adv;
      logic front;
      adv = en && (!step_mode || step_req);
      if (!adv || mState >= 2) return 7'b0010100;
      if (mState == 1) return 7'b0011011;
      front = load_pc || !bubble;
      return {front, front, !load_pc, 1'b1, !(load_pc || bubble), 1'b1, 1'b1};
   endfunction

   task automatic modelStep();
      logic adv;
      adv = en && (!step_mode || step_req);
      if (mState == 0) begin
         if (adv) begin
            mCyc = satInc(mCyc);
            if (load_pc) mFlush = satInc(mFlush);
            else if (bubble) mStall = satInc(mStall);
            if (halt_ex) begin
               mState = 1;
               mDrain = 0;
            end
         end
      end else if (mState == 1) begin
         if (adv) begin
            mCyc   = satInc(mCyc);
            mDrain = mDrain + 1;
         end
         if (halted_wb) mState = 2;
         else if (adv && mDrain >= DRAIN_MAX) mState = 3;
      end
   endtask

   task automatic modelReset();
      mState = 0;
      mDrain = 0;
      mCyc   = 0;
      mStall = 0;
      mFlush = 0;
   endtask

   initial begin
      int eC;
      int eS;
      int eF;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111111, 1, 0, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0011011, 1, 1, 0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1101011, 1, 0, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1101011, 1, 0, 1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0010100, 0, 0, 0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0010100, 0, 0, 0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111111, 1, 0, 0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111111, 1, 0, 0};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0011011, 1, 1, 0};
      vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0010100, 0, 0, 0};

      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      #2;
      checkOutput("reset state", 32'(state), 0);
      checkOutput("reset halted", 32'(halted), 0);
      checkCounters("reset", 0, 0, 0);
      tick();
      rst_n = 1'b1;

      // Free run with no hazards
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         #3;
         checkOutput("run enables", 32'(packEn()), 32'(7'b1111111));
         tick();
      end
      checkCounters("run10", 10, 0, 0);

      // Vector table
      eC = 10;
      eS = 0;
      eF = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].en, vecs[i].sm, vecs[i].sr, vecs[i].b, vecs[i].lp, 0, 0);
         #3;
         checkOutput($sformatf("vec%0d enables", i), 32'(packEn()), 32'(vecs[i].expEn));
         tick();
         eC += vecs[i].cycInc;
         eS += vecs[i].stallInc;
         eF += vecs[i].flushInc;
         checkOutput($sformatf("vec%0d state", i), 32'(state), 0);
         checkCounters($sformatf("vec%0d", i), eC, eS, eF);
      end

      // Single step: idle, isolated pulses, then a two-cycle held request
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("step idle pc_en", 32'(pc_en), 0);
      checkOutput("step idle cycle_cnt", 32'(cycle_cnt), eC);
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         tick();
      end
      checkOutput("step pulses cycle_cnt", 32'(cycle_cnt), eC + 3);
      step_req = 1'b1;
      tick();
      tick();
      step_req = 1'b0;
      checkOutput("step held cycle_cnt", 32'(cycle_cnt), eC + 5);

      // Halt with simultaneous branch, drain, then freeze
      doReset();
      applyStimulus(1, 0, 0, 0, 1, 1, 0);
      #3;
      checkOutput("halt+branch pc_en", 32'(pc_en), 1);
      checkOutput("halt+branch if_id_clr_n", 32'(if_id_clr_n), 0);
      tick();
      checkOutput("halt state after 1", 32'(state), 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      #3;
      checkOutput("drain enables", 32'(packEn()), 32'(7'b0011011));
      tick();
      checkOutput("halt state after 2", 32'(state), 1);
      halted_wb = 1'b1;
      tick();
      checkOutput("halt state after 3", 32'(state), 2);
      checkOutput("halt halted", 32'(halted), 1);
      checkCounters("halt", 3, 0, 1);
      applyStimulus(1, 1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #3;
         checkOutput("frozen enables", 32'(packEn()), 32'(7'b0010100));
         tick();
      end
      checkOutput("frozen state", 32'(state), 2);
      checkCounters("frozen", 3, 0, 1);

      // Drain timeout, including a non-advancing drain cycle
      doReset();
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("timeout hold state", 32'(state), 1);
      en = 1'b1;
      tick();
      tick();
      checkOutput("timeout pre state", 32'(state), 1);
      tick();
      checkOutput("timeout state", 32'(state), 3);
      checkOutput("timeout halted", 32'(halted), 1);

      // halted_wb on the final drain advance beats the timeout
      doReset();
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      tick();
      halt_ex = 1'b0;
      tick();
      tick();
      halted_wb = 1'b1;
      tick();
      checkOutput("wb priority state", 32'(state), 2);

      // Counter saturation, then asynchronous reset mid-drain
      doReset();
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < SAT - 1; i++) tick();
      checkOutput("sat pre stall_cnt", 32'(stall_cnt), SAT - 1);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("sat stall_cnt", 32'(stall_cnt), SAT);
      checkOutput("sat cycle_cnt", 32'(cycle_cnt), SAT);
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      tick();
      halt_ex = 1'b0;
      tick();
      checkOutput("mid-drain state", 32'(state), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async reset state", 32'(state), 0);
      checkOutput("async reset halted", 32'(halted), 0);
      checkCounters("async reset", 0, 0, 0);
      rst_n = 1'b1;

      // Randomized traffic against the behavioural model
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      doReset();
      modelReset();
      for (int i = 0; i < 600; i++) begin
         if (mState >= 2 && $urandom_range(0, 3) == 0) begin
            doReset();
            modelReset();
         end
         applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 2) == 0);
         if (mState == 1) begin
            bubble  = 1'b0;
            load_pc = 1'b0;
         end
         #2;
         checkOutput("rand enables", 32'(packEn()), 32'(modelEn()));
         modelStep();
         tick();
         checkOutput("rand state", 32'(state), mState);
         checkOutput("rand halted", 32'(halted), (mState >= 2) ? 1 : 0);
         checkCounters("rand", mCyc, mStall, mFlush);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
